// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Build option: IF_PERF_CNT_EN adds fetch/bubble performance counters to the top level.
package if_pkg;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } if_state_e;

   // Debug view of the fetch FSM and the skid buffer occupancy.
   typedef struct packed {
      if_state_e state;
      logic      skid_valid;
   } if_dbg_t;

   localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;
   localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc_4} holding register for a fetch that completes while ID is stalled.
// Clear wins over load; the top level never asserts both in one cycle.
module if_skid_buf
   import if_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] inst_in,
   input  logic [31:0] pc_4_in,
   output logic [31:0] inst,
   output logic [31:0] pc_4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         inst  <= IF_NOP_INST;
         pc_4  <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         inst  <= inst_in;
         pc_4  <= pc_4_in;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage_unit.sv
// Instruction fetch with predict-not-taken sequencing, one-entry skid buffer and IF/ID register.
// Build option: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt outputs.
module if_stage_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic        IF_ID_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ID_inst,
   output logic [31:0] ID_pc_4,
   output logic        ID_valid,
   output logic [31:0] pc,
   output if_dbg_t     dbg
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   if_state_e   state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pc_plus_4;
   logic        fetch_done;
   logic        id_load;
   logic [31:0] id_inst_nxt;
   logic [31:0] id_pc_4_nxt;
   logic        id_valid_nxt;
   logic        buf_load;
   logic        buf_clear;
   logic [31:0] buf_inst;
   logic [31:0] buf_pc_4;
   logic        buf_valid;

   // Imem handshake: a fetch completes in exactly the cycle where imem_req and imem_ready
   // are both high; imem_rdata is only meaningful in that cycle and is never held by memory.
   assign imem_req   = cpu_en & ~reset & (state == S_FETCH);
   assign imem_addr  = pc;
   assign fetch_done = imem_req & imem_ready;
   assign pc_plus_4  = pc + PC_INC;
   assign dbg        = '{state: state, skid_valid: buf_valid};

   if_skid_buf u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (buf_load),
      .clear   (buf_clear),
      .inst_in (imem_rdata),
      .pc_4_in (pc_plus_4),
      .inst    (buf_inst),
      .pc_4    (buf_pc_4),
      .valid   (buf_valid)
   );

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      id_load      = 1'b0;
      id_inst_nxt  = NOP_INST;
      id_pc_4_nxt  = '0;
      id_valid_nxt = 1'b0;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      if (cpu_en) begin
         if (redirect_valid) begin
            // Taken branch squashes whatever is in flight, including a same-cycle fetch.
            pc_nxt    = redirect_pc & ~32'h3;
            id_load   = 1'b1;
            buf_clear = 1'b1;
            state_nxt = S_FETCH;
         end else if (IF_ID_stall) begin
            if (state == S_FETCH && fetch_done) begin
               buf_load  = 1'b1;
               pc_nxt    = pc_plus_4;
               state_nxt = S_HOLD;
            end
         end else if (state == S_HOLD) begin
            id_load      = 1'b1;
            id_inst_nxt  = buf_inst;
            id_pc_4_nxt  = buf_pc_4;
            id_valid_nxt = 1'b1;
            buf_clear    = 1'b1;
            state_nxt    = S_FETCH;
         end else if (fetch_done) begin
            id_load      = 1'b1;
            id_inst_nxt  = imem_rdata;
            id_pc_4_nxt  = pc_plus_4;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc_plus_4;
         end else begin
            id_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ID_inst  <= NOP_INST;
         ID_pc_4  <= '0;
         ID_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (id_load) begin
            ID_inst  <= id_inst_nxt;
            ID_pc_4  <= id_pc_4_nxt;
            ID_valid <= id_valid_nxt;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   // Counters follow IF/ID loads only; stall-hold cycles load nothing and count nothing.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else if (id_load) begin
         if (id_valid_nxt) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
         else              perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed plus random bench for if_stage_unit against a queue-based fetch model.
// Build option: IF_PERF_CNT_EN also checks the performance counters.
module tb_if_stage_unit;
   import if_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset, cpu_en, IF_ID_stall, redirect_valid, imem_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, ID_valid;
   logic [31:0] imem_addr, ID_inst, ID_pc_4, pc;
   if_dbg_t     dbg;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   if_stage_unit dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_en         (cpu_en),
      .IF_ID_stall    (IF_ID_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ID_inst        (ID_inst),
      .ID_pc_4        (ID_pc_4),
      .ID_valid       (ID_valid),
      .pc             (pc),
      .dbg            (dbg)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model state: held fetches live in exp_q as {inst, pc_4}
   logic [63:0] exp_q[$];
   logic [31:0] m_pc, m_inst, m_pc_4;
   logic        m_valid;
   logic [31:0] m_fetch_cnt, m_bubble_cnt;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = IF_NOP_INST; m_pc_4 = 32'h0; m_valid = 1'b0;
      m_fetch_cnt = 32'h0; m_bubble_cnt = 32'h0;
      exp_q.delete();
   endtask

   task automatic model_bubble();
      m_inst = IF_NOP_INST; m_pc_4 = 32'h0; m_valid = 1'b0;
      m_bubble_cnt++;
   endtask

   task automatic model_step(input logic en, rst, stall, redir, input logic [31:0] rpc,
                             input logic rdy);
      logic        done;
      logic [63:0] e;
      if (rst) begin
         model_reset();
      end else if (en) begin
         done = (exp_q.size() == 0) && rdy;
         if (redir) begin
            m_pc = {rpc[31:2], 2'b00};
            exp_q.delete();
            model_bubble();
         end else if (stall) begin
            if (done) begin
               exp_q.push_back({m_pc ^ KEY, m_pc + 32'd4});
               m_pc = m_pc + 32'd4;
            end
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m_inst = e[63:32]; m_pc_4 = e[31:0]; m_valid = 1'b1;
            m_fetch_cnt++;
         end else if (done) begin
            m_inst = m_pc ^ KEY; m_pc_4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch_cnt++;
         end else begin
            model_bubble();
         end
      end
   endtask

   task automatic check_all();
      chk("imem_req", {31'b0, imem_req},
          {31'b0, cpu_en & ~reset & (exp_q.size() == 0)});
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("ID_inst", ID_inst, m_inst);
      chk("ID_pc_4", ID_pc_4, m_pc_4);
      chk("ID_valid", {31'b0, ID_valid}, {31'b0, m_valid});
      chk("skid_valid", {31'b0, dbg.skid_valid}, {31'b0, exp_q.size() != 0});
      chk("hold_state", {31'b0, dbg.state == S_HOLD}, {31'b0, exp_q.size() != 0});
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
      chk("perf_bubble_cnt", perf_bubble_cnt, m_bubble_cnt);
`endif
   endtask

   // driver: apply one cycle of inputs, check outputs mid-cycle, advance model at the edge
   task automatic cycle(input logic en, rst, stall, redir, input logic [31:0] rpc,
                        input logic rdy);
      @(negedge clk);
      cpu_en = en; reset = rst; IF_ID_stall = stall; redirect_valid = redir;
      redirect_pc = rpc; imem_ready = rdy; imem_rdata = m_pc ^ KEY;
      #1 check_all();
      @(posedge clk);
      model_step(en, rst, stall, redir, rpc, rdy);
   endtask

   initial begin
      cpu_en = 1'b0; reset = 1'b1; IF_ID_stall = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      // reset held: imem_req must stay low
      cycle(1, 1, 0, 0, 32'h0, 1);
      // sequential stream 0,4,8,c
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 32'h0, 1);
      // stall 3 cycles while fetch at 0x10 completes, then release
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h0, 1);
      // redirect with simultaneous stall to unaligned 0x103
      cycle(1, 0, 1, 1, 32'h0000_0103, 1);
      for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 32'h0, 1);
      // imem not ready for two cycles
      for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 32'h0, 0);
      cycle(1, 0, 0, 0, 32'h0, 1);
      // freeze for four cycles, inputs wiggling
      for (int i = 0; i < 4; i++) cycle(0, 0, i[0], i[1], 32'h0000_0400, 1);
      for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 32'h0, 1);
      // reset while holding a buffered fetch
      cycle(1, 0, 1, 0, 32'h0, 1);
      cycle(1, 0, 1, 0, 32'h0, 1);
      cycle(1, 1, 1, 0, 32'h0, 1);
      cycle(1, 0, 0, 0, 32'h0, 1);
      // pc wrap from 0xFFFF_FFFC
      cycle(1, 0, 0, 1, 32'hFFFF_FFFF, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h0, 1);
      // random traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom, $urandom_range(0, 3) != 0);
      @(negedge clk);
      #1 check_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
